rx_stream_packetizer: RTL and testbench
=======================================

Name: rx_stream_packetizer

Overview:
- Transmit end of the 32-bit RX sample stream consumed by the design_main RX_0 port (tdata/tvalid/tready).
- Accepts one free-running sample per qualifying cycle on the ref_clk domain.
- Groups samples into fixed-length packets, each led by a 3-word header: magic/sequence, second count, tic of first sample.
- Buffers samples so downstream backpressure never stalls the source; whole packets are dropped on overflow so packet framing stays intact.

Parameters:
- DATA_DEPTH_LOG2, 10, log2 depth of sample FIFO (1024 words).
- HDR_DEPTH_LOG2, 2, log2 depth of header FIFO (4 entries of 64 bits: sec, tic).
- MAGIC, 16'hA55A, constant in the upper half of header word 0.

Ports:
- clk  in  1  ref_clk domain clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; packets start only while high.
- pkt_len  in  16  samples per packet, sampled at packet start; 0 is treated as 1.
- sec  in  32  current second from timebase.
- tic  in  32  current tic within second from timebase.
- s_data  in  32  sample word.
- s_valid  in  1  sample strobe; no backpressure to source.
- m_tdata  out  32  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on last sample word of a packet.
- drop_cnt  out  32  packets dropped, saturating.
- busy  out  1  high while any packet is buffered or in transmission.

Behaviour:
- Reset: all outputs 0; FIFOs empty; sequence = 0; write FSM in W_IDLE; read FSM in R_IDLE.
- Write FSM, states W_IDLE / W_FILL / W_DROP:
  - W_IDLE, on s_valid && enable: latch len = max(pkt_len, 1).
  - If data FIFO free space >= len and header FIFO not full: push {sec, tic} into the header FIFO, write the sample, set remaining = len-1, go to W_FILL (or stay in W_IDLE if len == 1).
  - Otherwise: increment drop_cnt (saturating at 2^32-1), set remaining = len-1, go to W_DROP (or stay in W_IDLE if len == 1).
  - W_FILL: each s_valid writes a sample and decrements remaining; returns to W_IDLE after the last sample.
  - W_DROP: each s_valid discards a sample and decrements remaining; returns to W_IDLE after the last sample.
  - enable falling mid-packet does not truncate the packet: it completes.
  - Free space is checked once at packet start, so the FIFO can never overflow mid-packet.
- Read FSM, states R_IDLE / R_H0 / R_H1 / R_H2 / R_DATA:
  - R_IDLE -> R_H0 when the header FIFO is non-empty; its length comes from a parallel 16-bit length FIFO pushed with the header.
  - R_H0: m_tdata = {MAGIC, seq[15:0]}.
  - R_H1: m_tdata = sec.
  - R_H2: m_tdata = tic.
  - R_DATA: pops len samples; m_tlast on the final one.
  - Each state advances only on m_tvalid && m_tready.
  - m_tvalid, m_tdata and m_tlast must hold stable while m_tvalid && !m_tready.
  - seq increments after the tlast beat and wraps 0xFFFF -> 0.
  - The header FIFO pops on the R_H2 handshake.
- Throughput: one word per cycle with m_tready held high; no bubble between consecutive packets.
  - R_DATA -> R_H0 on the same edge as the tlast handshake when another header is queued.
- Latency: first sample at s_valid edge N appears as header word 0 with m_tvalid high by edge N+3.
- Simultaneous FIFO write and read is permitted; free-space count uses registered occupancy, so it is conservative by at most one.
- Header data is coherent: sec and tic are captured on the same edge as the first sample write.
- busy = header FIFO non-empty || read FSM != R_IDLE || write FSM == W_FILL.
- Async reset mid-packet returns everything to reset state immediately; no partial packet is emitted afterwards.

Decomposition:
- Package rx_stream_pkg holds:
  - read/write FSM state enums;
  - HDR_WORDS = 3;
  - MAGIC default;
  - header word 0 packing function.
- Sub-module sync_fifo (params WIDTH, DEPTH_LOG2; ports wr_en, din, rd_en, dout, empty, full, count) provides one-cycle read-ahead (first-word-fall-through).
- It is instanced three times: data (32 bits), header (64 bits), length (16 bits).

Test Plan:
- pkt_len=4, sec=7, tic=100 at first sample, m_tready=1, 4 contiguous samples 1..4 -> beats A55A0000, 7, 100, 1, 2, 3, 4; tlast only on 4; seq next 1.
- Back-to-back packets of pkt_len=2 with m_tready=1 -> 10 beats with no idle cycle between packets; header words 0 carry seq 0 then 1.
- m_tready toggling 1010 during a packet -> tdata/tvalid/tlast stable on stalled cycles; word order unchanged.
- m_tready=0 while three 512-sample packets arrive (DATA_DEPTH_LOG2=10) -> packets 1–2 buffered, packet 3 dropped; drop_cnt=1; after release exactly 2 packets emitted.
- Assert rst during R_DATA of a pkt_len=8 packet -> outputs 0 next cycle; a new packet afterwards starts with seq 0 and full header.
- pkt_len=0, one sample -> packet of 1 sample; 4 beats, tlast on beat 4.

Source files
------------

// File: rtl/rx_stream_pkg.sv
// Shared types and helpers for the RX stream packetizer: FSM state encodings,
// header layout constants and header word 0 packing.
package rx_stream_pkg;

  localparam int unsigned HDR_WORDS     = 3;
  localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wr_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_H0,
    R_H1,
    R_H2,
    R_DATA
  } rd_state_e;

  function automatic logic [31:0] hdr_word0(input logic [15:0] magic, input logic [15:0] seq);
    return {magic, seq};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: dout always shows the head entry
// while not empty, and rd_en consumes it.
module sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/rx_stream_packetizer.sv
// Packs a free-running 32-bit sample stream into headered fixed-length packets
// on an AXI-Stream style master, dropping whole packets when buffering runs out.
module rx_stream_packetizer
  import rx_stream_pkg::*;
#(
  parameter int unsigned DATA_DEPTH_LOG2 = 10,
  parameter int unsigned HDR_DEPTH_LOG2  = 2,
  parameter logic [15:0] MAGIC           = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] pkt_len,
  input  logic [31:0] sec,
  input  logic [31:0] tic,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [31:0] drop_cnt,
  output logic        busy
);

  localparam int unsigned DATA_DEPTH = 1 << DATA_DEPTH_LOG2;
  localparam int unsigned DCW        = DATA_DEPTH_LOG2 + 1;
  localparam int unsigned HCW        = HDR_DEPTH_LOG2 + 1;

  wr_state_e   wr_state_q;
  rd_state_e   rd_state_q;
  logic [15:0] wr_rem_q;
  logic [15:0] rd_rem_q;
  logic [15:0] seq_q;
  logic [31:0] drop_cnt_q;
  logic [31:0] m_tdata_q;
  logic        m_tvalid_q;
  logic        m_tlast_q;
  logic        busy_q;

  logic [31:0]    data_dout;
  logic           data_empty;
  logic           data_full;
  logic [DCW-1:0] data_count;
  logic [63:0]    hdr_dout;
  logic           hdr_empty;
  logic           hdr_full;
  logic [HCW-1:0] hdr_count;
  logic [15:0]    len_dout;
  logic           len_empty;
  logic           len_full;
  logic [HCW-1:0] len_count;

  logic [15:0]    wr_len_c;
  logic [DCW-1:0] free_c;
  logic           start_c;
  logic           accept_c;
  logic           hdr_push_c;
  logic           data_wr_c;
  logic           hs_c;
  logic           out_free_c;
  logic           hdr_pop_c;
  logic           data_pop_c;
  logic           unused_c;

  assign wr_len_c   = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
  assign free_c     = DCW'(DATA_DEPTH) - data_count;
  assign start_c    = (wr_state_q == W_IDLE) && s_valid && enable;
  assign accept_c   = (32'(free_c) >= 32'(wr_len_c)) && !hdr_full && !len_full;
  assign hdr_push_c = start_c && accept_c;
  assign data_wr_c  = hdr_push_c || ((wr_state_q == W_FILL) && s_valid);
  assign hs_c       = m_tvalid_q && m_tready;
  assign out_free_c = !m_tvalid_q || m_tready;
  assign unused_c   = ^{data_full, hdr_count, len_count, len_empty};

  // Header and length leave together on the last header beat; data is pulled as the output frees up.
  always_comb begin
    hdr_pop_c  = 1'b0;
    data_pop_c = 1'b0;
    case (rd_state_q)
      R_H2: begin
        if (hs_c) begin
          hdr_pop_c  = 1'b1;
          data_pop_c = !data_empty;
        end
      end
      R_DATA: begin
        if (out_free_c && (rd_rem_q != 16'd0)) begin
          data_pop_c = !data_empty;
        end
      end
      default: ;
    endcase
  end

  sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DATA_DEPTH_LOG2)) u_data_fifo (
    .clk(clk), .rst(rst), .wr_en(data_wr_c), .din(s_data), .rd_en(data_pop_c),
    .dout(data_dout), .empty(data_empty), .full(data_full), .count(data_count)
  );

  sync_fifo #(.WIDTH(64), .DEPTH_LOG2(HDR_DEPTH_LOG2)) u_hdr_fifo (
    .clk(clk), .rst(rst), .wr_en(hdr_push_c), .din({sec, tic}), .rd_en(hdr_pop_c),
    .dout(hdr_dout), .empty(hdr_empty), .full(hdr_full), .count(hdr_count)
  );

  sync_fifo #(.WIDTH(16), .DEPTH_LOG2(HDR_DEPTH_LOG2)) u_len_fifo (
    .clk(clk), .rst(rst), .wr_en(hdr_push_c), .din(wr_len_c), .rd_en(hdr_pop_c),
    .dout(len_dout), .empty(len_empty), .full(len_full), .count(len_count)
  );

  // Write side: admission is decided once per packet, so a started packet never overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_rem_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (start_c) begin
            wr_rem_q <= wr_len_c - 16'd1;
            if (wr_len_c != 16'd1) begin
              wr_state_q <= accept_c ? W_FILL : W_DROP;
            end
            if (!accept_c && (drop_cnt_q != '1)) begin
              drop_cnt_q <= drop_cnt_q + 32'd1;
            end
          end
        end
        W_FILL, W_DROP: begin
          if (s_valid) begin
            wr_rem_q <= wr_rem_q - 16'd1;
            if (wr_rem_q == 16'd1) begin
              wr_state_q <= W_IDLE;
            end
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Read side: state names the word currently presented; the next word is loaded on its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_rem_q   <= '0;
      seq_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= !hdr_empty || (rd_state_q != R_IDLE) || (wr_state_q == W_FILL);
      case (rd_state_q)
        R_IDLE: begin
          if (!hdr_empty) begin
            rd_state_q <= R_H0;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= hdr_word0(MAGIC, seq_q);
          end
        end
        R_H0: begin
          if (hs_c) begin
            rd_state_q <= R_H1;
            m_tdata_q  <= hdr_dout[63:32];
          end
        end
        R_H1: begin
          if (hs_c) begin
            rd_state_q <= R_H2;
            m_tdata_q  <= hdr_dout[31:0];
          end
        end
        R_H2: begin
          if (hs_c) begin
            rd_state_q <= R_DATA;
            if (data_pop_c) begin
              m_tdata_q <= data_dout;
              m_tlast_q <= (len_dout == 16'd1);
              rd_rem_q  <= len_dout - 16'd1;
            end else begin
              m_tvalid_q <= 1'b0;
              rd_rem_q   <= len_dout;
            end
          end
        end
        R_DATA: begin
          if (rd_rem_q == 16'd0) begin
            if (hs_c) begin
              seq_q     <= seq_q + 16'd1;
              m_tlast_q <= 1'b0;
              if (!hdr_empty) begin
                rd_state_q <= R_H0;
                m_tdata_q  <= hdr_word0(MAGIC, seq_q + 16'd1);
              end else begin
                rd_state_q <= R_IDLE;
                m_tvalid_q <= 1'b0;
                m_tdata_q  <= '0;
              end
            end
          end else if (out_free_c) begin
            if (data_pop_c) begin
              m_tvalid_q <= 1'b1;
              m_tdata_q  <= data_dout;
              m_tlast_q  <= (rd_rem_q == 16'd1);
              rd_rem_q   <= rd_rem_q - 16'd1;
            end else begin
              m_tvalid_q <= 1'b0;
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rx_stream_packetizer.sv
// Directed bench for rx_stream_packetizer: table of single-packet cases plus
// hand-written back-to-back, stall, overflow and reset sequences.
module tb_rx_stream_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] pkt_len;
  logic [31:0] sec;
  logic [31:0] tic;
  logic [31:0] s_data;
  logic        s_valid;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] drop_cnt;
  logic        busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [15:0] pkt_len;
    int unsigned nsamp;
    logic [31:0] sec;
    logic [31:0] tic;
    logic [31:0] first;
    int unsigned exp_beats;
  } case_t;

  beat_t       got_q[$];
  int unsigned got_cyc[$];

  rx_stream_packetizer dut (
    .clk(clk), .rst(rst), .enable(enable), .pkt_len(pkt_len), .sec(sec), .tic(tic),
    .s_data(s_data), .s_valid(s_valid), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      got_q.push_back('{m_tdata, m_tlast});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at posedge+1, returns at posedge+1; sec/tic move after the first sample.
  task automatic send_packet(input logic [15:0] len_in, input int unsigned n,
                             input logic [31:0] s, input logic [31:0] t, input logic [31:0] first);
    pkt_len = len_in;
    enable  = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      sec     = s + 32'(i);
      tic     = t + 32'(i);
      s_valid = 1'b1;
      s_data  = first + 32'(i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    sec     = 32'hEEEE_0000;
    tic     = 32'hEEEE_1111;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    repeat (4) begin @(posedge clk); #1; end
    while ((busy || m_tvalid) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy || m_tvalid) begin
      failures++;
      $display("FAIL %s drain_timeout busy=%0b tvalid=%0b", name, busy, m_tvalid);
    end
  endtask

  task automatic chk_packet(input string name, input int unsigned base, input logic [15:0] seq,
                            input logic [31:0] s, input logic [31:0] t, input logic [31:0] first,
                            input int unsigned n);
    for (int i = 0; i < int'(n) + 3; i++) begin
      logic [31:0] ed;
      logic        el;
      ed = (i == 0) ? {16'hA55A, seq} : (i == 1) ? s : (i == 2) ? t : first + 32'(i - 3);
      el = (i == int'(n) + 2);
      if (base + i >= got_q.size()) begin
        checks++;
        failures++;
        $display("FAIL %s beat%0d missing got=none exp=%h", name, i, ed);
      end else begin
        chk($sformatf("%s beat%0d", name, i),
            {31'b0, got_q[base+i].last, got_q[base+i].data}, {31'b0, el, ed});
      end
    end
  endtask

  case_t       cases[4];
  logic [15:0] exp_seq;
  int unsigned base;
  int unsigned n;
  logic        was_stall;
  logic [31:0] held_data;
  logic        held_last;

  initial begin
    cases[0] = '{16'd4, 4, 32'd7,          32'd100,        32'd1,          7};
    cases[1] = '{16'd0, 1, 32'h11,         32'h22,         32'hDEAD_BEEF,  4};
    cases[2] = '{16'd1, 1, 32'd3,          32'd5,          32'd9,          4};
    cases[3] = '{16'd5, 5, 32'hFFFF_FFFF,  32'h0,          32'h100,        8};

    rst = 1'b1; enable = 1'b0; pkt_len = '0; sec = '0; tic = '0;
    s_data = '0; s_valid = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset tvalid", 64'(m_tvalid), 64'd0);
    chk("reset tdata", 64'(m_tdata), 64'd0);
    chk("reset tlast", 64'(m_tlast), 64'd0);
    chk("reset drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    exp_seq = 16'd0;
    for (int c = 0; c < 4; c++) begin
      base = got_q.size();
      send_packet(cases[c].pkt_len, cases[c].nsamp, cases[c].sec, cases[c].tic, cases[c].first);
      drain($sformatf("case%0d", c));
      chk($sformatf("case%0d beat_count", c), 64'(got_q.size() - base), 64'(cases[c].exp_beats));
      chk_packet($sformatf("case%0d", c), base, exp_seq, cases[c].sec, cases[c].tic,
                 cases[c].first, cases[c].exp_beats - 3);
      exp_seq++;
    end

    // Back-to-back two-sample packets must stream with no idle cycle.
    base = got_q.size();
    send_packet(16'd2, 2, 32'd50, 32'd60, 32'hA0);
    send_packet(16'd2, 2, 32'd70, 32'd80, 32'hB0);
    drain("b2b");
    chk("b2b beat_count", 64'(got_q.size() - base), 64'd10);
    chk_packet("b2b p0", base, exp_seq, 32'd50, 32'd60, 32'hA0, 2);
    chk_packet("b2b p1", base + 5, exp_seq + 16'd1, 32'd70, 32'd80, 32'hB0, 2);
    if (got_cyc.size() >= base + 10)
      chk("b2b span_cycles", 64'(got_cyc[base+9] - got_cyc[base]), 64'd9);
    exp_seq += 16'd2;

    // Ready toggling 1010: held outputs on every stalled cycle.
    m_tready = 1'b0;
    base = got_q.size();
    send_packet(16'd3, 3, 32'd21, 32'd22, 32'h300);
    @(negedge clk);
    was_stall = m_tvalid && !m_tready;
    held_data = m_tdata;
    held_last = m_tlast;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      m_tready = (i % 2 == 0);
      @(negedge clk);
      if (was_stall)
        chk($sformatf("stall_hold cyc%0d", i), {31'b0, m_tvalid, m_tdata}, {31'b0, 1'b1, held_data});
      if (was_stall)
        chk($sformatf("stall_last cyc%0d", i), 64'(m_tlast), 64'(held_last));
      was_stall = m_tvalid && !m_tready;
      held_data = m_tdata;
      held_last = m_tlast;
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    drain("toggle");
    chk("toggle beat_count", 64'(got_q.size() - base), 64'd6);
    chk_packet("toggle", base, exp_seq, 32'd21, 32'd22, 32'h300, 3);
    exp_seq++;

    // Overflow: three 512-sample packets into a 1024-word buffer with the sink stalled.
    m_tready = 1'b0;
    base = got_q.size();
    send_packet(16'd512, 512, 32'd1000, 32'd2000, 32'h1000);
    send_packet(16'd512, 512, 32'd3000, 32'd4000, 32'h2000);
    send_packet(16'd512, 512, 32'd5000, 32'd6000, 32'h3000);
    repeat (5) begin @(posedge clk); #1; end
    chk("ovf drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf busy", 64'(busy), 64'd1);
    chk("ovf stalled_h0", {31'b0, m_tvalid, m_tdata}, {31'b0, 1'b1, 16'hA55A, exp_seq});
    m_tready = 1'b1;
    drain("ovf");
    chk("ovf beat_count", 64'(got_q.size() - base), 64'd1030);
    chk_packet("ovf p0", base, exp_seq, 32'd1000, 32'd2000, 32'h1000, 512);
    chk_packet("ovf p1", base + 515, exp_seq + 16'd1, 32'd3000, 32'd4000, 32'h2000, 512);
    chk("ovf drop_cnt_final", 64'(drop_cnt), 64'd1);

    // Reset in the middle of a packet's data beats.
    base = got_q.size();
    send_packet(16'd8, 8, 32'd77, 32'd88, 32'h800);
    n = 0;
    while (got_q.size() < base + 5 && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst reached_data", 64'(got_q.size() >= base + 5), 64'd1);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst tvalid", 64'(m_tvalid), 64'd0);
    chk("rst tdata", 64'(m_tdata), 64'd0);
    chk("rst tlast", 64'(m_tlast), 64'd0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_seq = 16'd0;
    base = got_q.size();
    repeat (3) begin @(posedge clk); #1; end
    chk("rst no_residual", 64'(got_q.size() - base), 64'd0);
    send_packet(16'd2, 2, 32'd11, 32'd12, 32'h900);
    drain("post_rst");
    chk("post_rst beat_count", 64'(got_q.size() - base), 64'd5);
    chk_packet("post_rst", base, exp_seq, 32'd11, 32'd12, 32'h900, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
